// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE row: FSM state encoding, default widths
// and the saturating adder used when the design is built with PE_SAT_EN.
package pe_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ACC_W  = 32;
  localparam int DEFAULT_LEN_W  = 8;

  // Working width of sat_add; any ACC_W up to this value is supported.
  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  // Adds two sign-extended operands and clamps the result to a w-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned              w);
    logic signed [SAT_W:0] full;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sat_res_t              r;
    full = $signed({a[SAT_W-1], a}) + $signed({b[SAT_W-1], b});
    hi   = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo   = -(65'sd1 <<< (w - 1));
    if (full > hi) begin
      r.sat = 1'b1;
      r.sum = hi[SAT_W-1:0];
    end else if (full < lo) begin
      r.sat = 1'b1;
      r.sum = lo[SAT_W-1:0];
    end else begin
      r.sat = 1'b0;
      r.sum = full[SAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mul_add.sv
// Combinational datapath of the PE: signed multiply, sign-extend to ACC_W and add.
// Wraps in the default build; saturates and reports it when PE_SAT_EN is defined.
module pe_mul_add
  import pe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
) (
  input  logic signed [DATA_W-1:0] ifmap,
  input  logic signed [DATA_W-1:0] filter,
  input  logic signed [ACC_W-1:0]  addend,
`ifdef PE_SAT_EN
  output logic                     sat,
`endif
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = ifmap * filter;
  assign prod_ext = ACC_W'(prod);

`ifdef PE_SAT_EN
  sat_res_t res;

  assign res = sat_add(SAT_W'(addend), SAT_W'(prod_ext), ACC_W);
  assign sum = res.sum[ACC_W-1:0];
  assign sat = res.sat;
`else
  assign sum = addend + prod_ext;
`endif

endmodule

// File: rtl/pe_mac.sv
// Handshaked multiply-accumulate PE: folds a window of cfg_len products onto an
// upstream seed psum and emits one result per window. Optional macro: PE_SAT_EN.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W,   // must be >= 2*DATA_W
  parameter int LEN_W  = DEFAULT_LEN_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_ifmap,
  input  logic signed [DATA_W-1:0] in_filter,
  input  logic signed [ACC_W-1:0]  in_psum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_psum,
`ifdef PE_SAT_EN
  output logic                     sat_flag,
`endif
  output logic                     busy
);

  state_t                  state;
  state_t                  state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        cnt_inc;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        len_eff;
  logic                    in_fire;
  logic                    out_fire;
`ifdef PE_SAT_EN
  logic                    sat;
`endif

  assign len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign cnt_inc  = cnt + LEN_W'(1);

  assign in_ready  = rst & en & (state != HOLD);
  assign out_valid = rst & en & (state == HOLD);
  assign out_psum  = acc;
  assign busy      = (state != IDLE);

  // Both ready/valid terms already carry en, so a frozen PE never fires.
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign addend = (state == IDLE) ? in_psum : acc;

  pe_mul_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mul_add (
    .ifmap  (in_ifmap),
    .filter (in_filter),
    .addend (addend),
`ifdef PE_SAT_EN
    .sat    (sat),
`endif
    .sum    (sum)
  );

  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_fire) state_nxt = (len_eff == LEN_W'(1)) ? HOLD : ACC;
      ACC:     if (in_fire && (cnt_inc == len_q)) state_nxt = HOLD;
      HOLD:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (en) begin
      state <= state_nxt;
      if (in_fire) begin
        acc <= sum;
        if (state == IDLE) begin
          cnt   <= LEN_W'(1);
          len_q <= len_eff;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

`ifdef PE_SAT_EN
  // Sticky per window: the first beat restarts it, later beats only OR in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_flag <= 1'b0;
    end else if (in_fire) begin
      sat_flag <= (state == IDLE) ? sat : (sat_flag | sat);
    end
  end
`endif

endmodule

// File: tb/tb_pe_mac.sv
// Self-checking bench for pe_mac: directed scenarios plus randomized windows
// compared against a plain-arithmetic window model.
module tb_pe_mac;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int LEN_W  = 8;

  logic              clk       = 1'b0;
  logic              rst       = 1'b0;
  logic              en        = 1'b0;
  logic [LEN_W-1:0]  cfg_len   = '0;
  logic              in_valid  = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_ifmap  = '0;
  logic [DATA_W-1:0] in_filter = '0;
  logic [ACC_W-1:0]  in_psum   = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_psum;
  logic              busy;
`ifdef PE_SAT_EN
  logic              sat_flag;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];

  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ifmap  (in_ifmap),
    .in_filter (in_filter),
    .in_psum   (in_psum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_psum  (out_psum),
`ifdef PE_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Window result straight from the arithmetic rule: seed plus the sum of
  // products, ACC_W wide (wrap or clamp after every add).
  task automatic ref_model(input logic [ACC_W-1:0] seed, output logic [ACC_W-1:0] res,
                           output logic sat);
    longint s;
    s   = longint'($signed(seed));
    sat = 1'b0;
    foreach (qa[i]) begin
      s = s + longint'($signed(qa[i])) * longint'($signed(qb[i]));
`ifdef PE_SAT_EN
      if (s > 64'sh7FFF_FFFF) begin
        s   = 64'sh7FFF_FFFF;
        sat = 1'b1;
      end else if (s < -64'sh8000_0000) begin
        s   = -64'sh8000_0000;
        sat = 1'b1;
      end
`endif
    end
    res = s[ACC_W-1:0];
  endtask

  // Streams qa/qb as one window; optional en stall after beat stall_at and
  // bp_n cycles of output backpressure before the transfer.
  task automatic run_window(input string name, input int cfg, input logic [ACC_W-1:0] seed,
                            input int stall_at, input int stall_n, input int bp_n);
    logic [ACC_W-1:0] exp;
    logic             exp_sat;
    int               n;
    n = (cfg == 0) ? 1 : cfg;
    ref_model(seed, exp, exp_sat);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_ifmap  = qa[i];
      in_filter = qb[i];
      in_psum   = (i == 0) ? seed : ACC_W'($urandom);
      cfg_len   = (i == 0) ? LEN_W'(cfg) : LEN_W'($urandom);
      #1;
      check({name, " in_ready"}, 64'(in_ready), 64'd1);
      check({name, " out_valid_early"}, 64'(out_valid), 64'd0);
      tick();
      if (i == stall_at) begin
        for (int k = 0; k < stall_n; k++) begin
          en = 1'b0;
          #1;
          check({name, " stall in_ready"}, 64'(in_ready), 64'd0);
          check({name, " stall out_valid"}, 64'(out_valid), 64'd0);
          tick();
        end
        en = 1'b1;
      end
    end
    in_valid = 1'b0;
    #1;
    check({name, " out_valid"}, 64'(out_valid), 64'd1);
    check({name, " hold in_ready"}, 64'(in_ready), 64'd0);
    check({name, " hold busy"}, 64'(busy), 64'd1);
    check({name, " out_psum"}, 64'(out_psum), 64'(exp));
`ifdef PE_SAT_EN
    check({name, " sat_flag"}, 64'(sat_flag), 64'(exp_sat));
`endif
    out_ready = 1'b0;
    for (int k = 0; k < bp_n; k++) begin
      tick();
      check({name, " bp out_valid"}, 64'(out_valid), 64'd1);
      check({name, " bp out_psum"}, 64'(out_psum), 64'(exp));
      check({name, " bp in_ready"}, 64'(in_ready), 64'd0);
    end
    en        = 1'b0;
    out_ready = 1'b1;
    #1;
    check({name, " en0 out_valid"}, 64'(out_valid), 64'd0);
    tick();
    en = 1'b1;
    #1;
    check({name, " en1 out_valid"}, 64'(out_valid), 64'd1);
    check({name, " en1 out_psum"}, 64'(out_psum), 64'(exp));
    tick();
    check({name, " done out_valid"}, 64'(out_valid), 64'd0);
    check({name, " done busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cfg;
    int n;

    // Reset with a beat offered: nothing may be accepted or produced.
    rst       = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cfg_len   = 8'd1;
    in_ifmap  = 16'd5;
    in_filter = 16'd5;
    tick();
    tick();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_psum", 64'(out_psum), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst release in_ready", 64'(in_ready), 64'd1);
    tick();

    qa = '{16'sd2, -16'sd4, 16'sd7};
    qb = '{16'sd3, 16'sd5, 16'sd1};
    run_window("basic", 3, 32'd10, -1, 0, 0);

    qa = '{-16'sd3};
    qb = '{-16'sd3};
    run_window("bp_seed", 1, 32'd0, -1, 0, 4);

    qa = '{16'sd11, -16'sd6, 16'sd300, -16'sd1234};
    qb = '{16'sd9, 16'sd13, -16'sd27, 16'sd5};
    run_window("stall", 4, 32'hFFFF_FF00, 1, 3, 0);
    run_window("nostall", 4, 32'hFFFF_FF00, -1, 0, 0);

    qa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    qb = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run_window("overflow", 4, 32'h7FFF_0000, -1, 0, 1);

    qa = '{16'sd1};
    qb = '{16'sd1};
    run_window("len0", 0, 32'd41, -1, 0, 0);

    // Reset after two beats of a five-beat window discards the partial sum.
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      in_ifmap  = 16'd100;
      in_filter = 16'd100;
      in_psum   = 32'd77;
      cfg_len   = 8'd5;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst out_psum", 64'(out_psum), 64'd0);
    rst = 1'b1;
    qa  = '{16'sd1};
    qb  = '{16'sd1};
    run_window("after_rst", 1, 32'd0, -1, 0, 0);

    for (int w = 0; w < 25; w++) begin
      cfg = $urandom_range(0, 6);
      n   = (cfg == 0) ? 1 : cfg;
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(DATA_W'($urandom));
        qb.push_back(DATA_W'($urandom));
      end
      run_window("rand", cfg, ACC_W'($urandom), $urandom_range(0, 7) - 1,
                 $urandom_range(1, 3), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_mac.md
Name: pe_mac

Overview:
- Parametrised, handshaked successor of the single-cycle PE.
- Accepts a stream of signed ifmap/filter pairs and accumulates cfg_len products onto a seed partial sum taken from the upstream PE.
- Emits one psum per window over a valid/ready output.
- Sits in the PE row of the accelerator; out_psum of one PE chains into in_psum of the next.

Parameters:
- DATA_W, 16, width of signed ifmap and filter operands
- ACC_W, 32, width of signed accumulator, in_psum and out_psum (must be >= 2*DATA_W)
- LEN_W, 8, width of the window-length configuration and internal counter

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-low reset
- en  input  1  global enable; 0 freezes all state and blocks both handshakes
- cfg_len  input  LEN_W  products per window; sampled on the first beat of a window; 0 is treated as 1
- in_valid  input  1  operand beat valid
- in_ready  output  1  PE can accept a beat
- in_ifmap  input  DATA_W  signed ifmap operand
- in_filter  input  DATA_W  signed filter operand
- in_psum  input  ACC_W  signed seed psum; used only on the first beat of a window
- out_valid  output  1  out_psum holds a completed window result
- out_ready  input  1  downstream accepts the result
- out_psum  output  ACC_W  signed accumulated result
- busy  output  1  window in progress or result pending

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; acc, cnt and len_q cleared to 0.
  - out_psum=0, out_valid=0, busy=0. in_ready=0 while rst=0.
  - Takes priority over en. Reset mid-window or mid-HOLD discards the partial result; no output is produced.
- Accept conditions:
  - Input beat accepted when in_valid & in_ready & en.
  - Output transferred when out_valid & out_ready & en.
- Product:
  - prod = signed(in_ifmap) * signed(in_filter), 2*DATA_W bits, sign-extended to ACC_W.
  - Add is ACC_W two's-complement and wraps on overflow (default).
- FSM states: IDLE, ACC, HOLD.
  - IDLE: in_ready=en, busy=0. On accept:
    - acc <= in_psum + prod; cnt <= 1; len_q <= max(cfg_len,1).
    - Next state is HOLD if len_q==1, else ACC.
  - ACC: in_ready=en, busy=1. On accept:
    - acc <= acc + prod; cnt <= cnt+1.
    - When cnt+1 == len_q, next state is HOLD.
    - No accept: hold state and values.
  - HOLD: in_ready=0, out_valid=en, out_psum=acc, busy=1.
    - On transfer: go to IDLE; acc is kept but no longer valid.
    - out_psum must stay stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises on the cycle after the final beat is accepted. Throughput is one window per len_q+1 cycles when out_ready is held high (one bubble for HOLD).
- en=0: every register holds its value; in_ready=0 and out_valid=0. When en returns, the previous state and values resume unchanged.
- cfg_len changes mid-window have no effect until the next window's first beat.
- in_psum is ignored on every beat except the first of a window.
- out_psum outside HOLD: drives acc (last value); consumers qualify with out_valid.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined:
  - Every add (seed and accumulate) saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A sticky output sat_flag (1 bit) is added. It is set on any saturation in the current window and cleared on the first beat of the next window and on reset.
- Undefined: two's-complement wrap; the sat_flag port is absent.

Decomposition:
- Shared package pe_pkg:
  - state enum {IDLE, ACC, HOLD}.
  - default DATA_W/ACC_W constants.
  - function sat_add(a,b) used under PE_SAT_EN.
- One natural sub-module, pe_mul_add: combinational signed multiply, sign-extend and add (wrap or saturate per PE_SAT_EN). pe_mac holds the FSM, counter and handshake registers.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_psum=0, in_ready=0, busy=0; after release in_ready=1.
- Basic window: cfg_len=3, in_psum=10, pairs (2,3),(-4,5),(7,1) streamed back-to-back, out_ready=1 -> out_valid exactly one cycle after the third beat, out_psum=3 (10+6-20+7), then IDLE.
- Backpressure and seed: cfg_len=1, ifmap=-3, filter=-3, in_psum=0; out_ready=0 for 4 cycles -> out_psum=9 held stable, in_ready=0 throughout, transfer on the cycle out_ready rises.
- Stall: cfg_len=4, en=0 for 3 cycles after beat 2 with in_valid=1 -> no beats accepted, cnt unchanged; result equals the unstalled run.
- Overflow, ACC_W=32, operands 0x7FFF*0x7FFF accumulated 4 times onto in_psum=0x7FFF0000:
  - without PE_SAT_EN: wrapped value 0x7FFF0000+4*0x3FFF0001 mod 2^32.
  - with PE_SAT_EN: 0x7FFFFFFF and sat_flag=1.
- Reset mid-window: rst=0 after beat 2 of cfg_len=5 -> no output; the next window with cfg_len=1, (1,1), in_psum=0 yields out_psum=1.
